mc_ctrl: RTL and testbench
==========================

# mc_ctrl

Multi-cycle control sequencer for the MIPS multi-cycle CPU. It replaces the free-running 3-bit phase counter with an opcode-aware state machine. Each instruction takes only the phases it needs, and the sequencer stalls on a memory ready handshake. Per-state datapath controls and the one-hot phase vector `p[4:0]` drive the PC, IR, register file, ALU and memory.

## Interface
Parameters:
- `OPW`, default 6: opcode width.

Ports:
- `clk`, in, 1: single clock. All state updates happen on the rising edge.
- `nclr`, in, 1: synchronous, active-low reset.
- `run`, in, 1: when high, leave IDLE and start fetching.
- `opcode`, in, OPW: IR[31:26]. Sampled in ID.
- `zero`, in, 1: ALU zero flag. Sampled in EX for beq.
- `mem_rdy`, in, 1: memory has completed the access this cycle.
- `p`, out, 5: one-hot phase. Bit 0 = IF, 1 = ID, 2 = EX, 3 = MEM, 4 = WB.
- `pc_write`, `ir_write`, `i_or_d`, `mem_read`, `mem_write`, `mem_to_reg`, `reg_write`, `reg_dst`, `alu_src_a`: out, 1 each. Classic multi-cycle datapath controls.
- `alu_src_b`, out, 2.
- `alu_op`, out, 2.
- `pc_src`, out, 2.
- `halted`, out, 1: sticky. Set by an illegal opcode.

## Operation
- States: IDLE, IF, ID, EX, MEM, WB, HALT.
- Reset (`nclr`=0 at an edge) → IDLE. All outputs 0 in IDLE and HALT; `p`=0.
- IDLE: go to IF when `run`=1, otherwise stay.
- IF:
  - Outputs: `mem_read`=1, `i_or_d`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=00, `pc_src`=00.
  - `ir_write` and `pc_write` are asserted only in the cycle where `mem_rdy`=1; that cycle transitions to ID.
  - While `mem_rdy`=0: stay in IF with `ir_write`=`pc_write`=0.
- ID: `alu_src_a`=0, `alu_src_b`=11, `alu_op`=00. Opcode decode:
  - 000000 (R-type), 100011 (lw), 101011 (sw), 000100 (beq), 001000 (addi) → EX.
  - 000010 (j) → EX.
  - Any other opcode → HALT; `halted` is set next cycle.
- EX:
  - R-type: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=10 → WB.
  - lw/sw/addi: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00. lw/sw → MEM; addi → WB.
  - beq: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=01, `pc_src`=01, `pc_write`=`zero` → IF (or IDLE if `run`=0).
  - j: `pc_src`=10, `pc_write`=1 → IF (or IDLE if `run`=0).
- MEM:
  - Outputs: `i_or_d`=1; `mem_read`=1 for lw, `mem_write`=1 for sw.
  - Hold until `mem_rdy`=1. Then lw → WB; sw → IF (or IDLE if `run`=0).
- WB:
  - `reg_write`=1 for one cycle.
  - R-type: `reg_dst`=1, `mem_to_reg`=0. lw: `reg_dst`=0, `mem_to_reg`=1. addi: `reg_dst`=0, `mem_to_reg`=0.
  - Next state: IF if `run`=1, else IDLE.
- The opcode class is latched into an internal register in ID. Later states use the latched class, not the live `opcode` input.
- HALT: absorbing state. Only `nclr` exits it; `halted` stays 1 until reset.

## Timing
- Moore outputs, decoded from the registered state (plus `zero`/`mem_rdy` gating where noted above). No output depends on `opcode` combinationally.
- Latency from IF entry with `mem_rdy` tied to 1:
  - beq, j: 3 cycles.
  - R-type, sw, addi: 4 cycles.
  - lw: 5 cycles.
- Every `mem_rdy`=0 cycle in IF or MEM adds exactly one cycle.
- `mem_rdy` outside IF and MEM is ignored.
- `run` is sampled only in IDLE and at instruction completion. Deasserting it mid-instruction lets the current instruction finish.
- `nclr`=0 in any state, including mid-stall, forces IDLE at the next edge and clears `halted` and the latched class.
- `p` is exactly one-hot in IF through WB.

## Structure
- `mc_pkg` holds:
  - state enum;
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI);
  - instruction-class enum;
  - `alu_op`, `alu_src_b` and `pc_src` encodings.
- Sub-module `mc_decode`: combinational opcode → {class, legal}. Instantiated once; its output is latched in ID.

## Test plan
- lw, `mem_rdy`=1 always, from reset with `run`=1 → `p` sequence 00001, 00010, 00100, 01000, 10000. `reg_write`=`mem_to_reg`=1 only in the 5th cycle.
- beq with `zero`=1, then beq with `zero`=0 → `pc_write`=1, `pc_src`=01 in EX only for the first; both return to IF after 3 cycles.
- sw with `mem_rdy` low for 3 cycles in MEM → MEM held 4 cycles with `mem_write`=1; no `reg_write`; then IF.
- Opcode 111111 in ID → HALT. `halted`=1 and all controls 0 for 10+ cycles, ignoring `run`. `nclr`=0 → IDLE, `halted`=0.
- `nclr` pulsed low during an IF stall → next cycle IDLE, `p`=0, `pc_write`=0.
- `run` dropped during an R-type EX → WB completes with `reg_write`=1, then IDLE.

Source files
------------

// File: rtl/mc_pkg.sv
// mc_pkg: shared types and encodings for the multi-cycle control sequencer.
package mc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_IF,
    ST_ID,
    ST_EX,
    ST_MEM,
    ST_WB,
    ST_HALT
  } state_e;

  typedef enum logic [2:0] {
    CL_RTYPE,
    CL_LW,
    CL_SW,
    CL_BEQ,
    CL_J,
    CL_ADDI
  } iclass_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_BROFF = 2'b11;

  localparam logic [1:0] PCSRC_ALU  = 2'b00;
  localparam logic [1:0] PCSRC_BR   = 2'b01;
  localparam logic [1:0] PCSRC_JUMP = 2'b10;

endpackage

// File: rtl/mc_decode.sv
// mc_decode: combinational opcode classifier; flags anything unsupported as illegal.
module mc_decode
  import mc_pkg::*;
#(
  parameter int OPW = 6
) (
  input  logic [OPW-1:0] opcode_i,
  output iclass_e        class_o,
  output logic           legal_o
);

  // Map the opcode field onto an instruction class
  always_comb begin
    class_o = CL_RTYPE;
    legal_o = 1'b1;
    if (opcode_i == OPW'(OP_RTYPE))     class_o = CL_RTYPE;
    else if (opcode_i == OPW'(OP_LW))   class_o = CL_LW;
    else if (opcode_i == OPW'(OP_SW))   class_o = CL_SW;
    else if (opcode_i == OPW'(OP_BEQ))  class_o = CL_BEQ;
    else if (opcode_i == OPW'(OP_J))    class_o = CL_J;
    else if (opcode_i == OPW'(OP_ADDI)) class_o = CL_ADDI;
    else                                legal_o = 1'b0;
  end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: opcode-aware multi-cycle control sequencer with memory-ready stalls.
module mc_ctrl
  import mc_pkg::*;
#(
  parameter int OPW = 6
) (
  input  logic           clk,
  input  logic           nclr,
  input  logic           run,
  input  logic [OPW-1:0] opcode,
  input  logic           zero,
  input  logic           mem_rdy,
  output logic [4:0]     p,
  output logic           pc_write,
  output logic           ir_write,
  output logic           i_or_d,
  output logic           mem_read,
  output logic           mem_write,
  output logic           mem_to_reg,
  output logic           reg_write,
  output logic           reg_dst,
  output logic           alu_src_a,
  output logic [1:0]     alu_src_b,
  output logic [1:0]     alu_op,
  output logic [1:0]     pc_src,
  output logic           halted
);

  state_e  state_q, state_d;
  iclass_e class_q, class_d;
  logic    halted_q, halted_d;
  iclass_e dec_class;
  logic    dec_legal;
  state_e  done_state;

  mc_decode #(.OPW(OPW)) u_decode (
    .opcode_i (opcode),
    .class_o  (dec_class),
    .legal_o  (dec_legal)
  );

  assign done_state = run ? ST_IF : ST_IDLE;
  assign halted     = halted_q;

  // State, latched instruction class and sticky halt flag
  always_ff @(posedge clk) begin
    if (!nclr) begin
      state_q  <= ST_IDLE;
      class_q  <= CL_RTYPE;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      class_q  <= class_d;
      halted_q <= halted_d;
    end
  end

  // Next-state selection and per-state datapath controls
  always_comb begin
    state_d    = state_q;
    class_d    = class_q;
    halted_d   = halted_q;
    p          = 5'b00000;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REG;
    alu_op     = ALUOP_ADD;
    pc_src     = PCSRC_ALU;
    case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_IF;
      end
      ST_IF: begin
        p         = 5'b00001;
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_rdy;
        pc_write  = mem_rdy;
        if (mem_rdy) state_d = ST_ID;
      end
      ST_ID: begin
        p         = 5'b00010;
        alu_src_b = SRCB_BROFF;
        if (dec_legal) begin
          class_d = dec_class;
          state_d = ST_EX;
        end else begin
          halted_d = 1'b1;
          state_d  = ST_HALT;
        end
      end
      ST_EX: begin
        p = 5'b00100;
        case (class_q)
          CL_RTYPE: begin
            alu_src_a = 1'b1;
            alu_op    = ALUOP_FUNCT;
            state_d   = ST_WB;
          end
          CL_LW, CL_SW: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
            state_d   = ST_MEM;
          end
          CL_ADDI: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
            state_d   = ST_WB;
          end
          CL_BEQ: begin
            alu_src_a = 1'b1;
            alu_op    = ALUOP_SUB;
            pc_src    = PCSRC_BR;
            pc_write  = zero;
            state_d   = done_state;
          end
          CL_J: begin
            pc_src   = PCSRC_JUMP;
            pc_write = 1'b1;
            state_d  = done_state;
          end
          default: state_d = ST_IDLE;
        endcase
      end
      ST_MEM: begin
        p         = 5'b01000;
        i_or_d    = 1'b1;
        mem_read  = (class_q == CL_LW);
        mem_write = (class_q == CL_SW);
        if (mem_rdy) state_d = (class_q == CL_LW) ? ST_WB : done_state;
      end
      ST_WB: begin
        p          = 5'b10000;
        reg_write  = 1'b1;
        reg_dst    = (class_q == CL_RTYPE);
        mem_to_reg = (class_q == CL_LW);
        state_d    = done_state;
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed and randomized checks of mc_ctrl against a phase-plan model.
module tb_mc_ctrl;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       nclr = 1'b0;
  logic       run = 1'b0;
  logic       zero = 1'b0;
  logic       mem_rdy = 1'b0;
  logic [5:0] opcode = 6'b0;

  logic [4:0] p;
  logic       pc_write, ir_write, i_or_d, mem_read, mem_write;
  logic       mem_to_reg, reg_write, reg_dst, alu_src_a, halted;
  logic [1:0] alu_src_b, alu_op, pc_src;

  mc_ctrl #(.OPW(6)) dut (
    .clk        (clk),
    .nclr       (nclr),
    .run        (run),
    .opcode     (opcode),
    .zero       (zero),
    .mem_rdy    (mem_rdy),
    .p          (p),
    .pc_write   (pc_write),
    .ir_write   (ir_write),
    .i_or_d     (i_or_d),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .pc_src     (pc_src),
    .halted     (halted)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit checkEn = 1'b0;

  // Model: which phase (0=IF..4=WB) is active and which phases the current instruction still needs
  bit mIdle = 1'b1;
  bit mHalt = 1'b0;
  int mPh = 0;
  int mKind = 0;
  int plan[$];

  logic [5:0] legalOps[6];

  function automatic int kindOf(input logic [5:0] op);
    case (op)
      OP_R:    return 0;
      OP_LW:   return 1;
      OP_SW:   return 2;
      OP_BEQ:  return 3;
      OP_J:    return 4;
      OP_ADDI: return 5;
      default: return -1;
    endcase
  endfunction

  task automatic modelStep();
    int k;
    if (!nclr) begin
      mIdle = 1'b1;
      mHalt = 1'b0;
      plan.delete();
    end else if (mHalt) begin
      mHalt = 1'b1;
    end else if (mIdle) begin
      if (run) begin
        mIdle = 1'b0;
        mPh   = 0;
      end
    end else if (mPh == 0) begin
      if (mem_rdy) mPh = 1;
    end else if (mPh == 1) begin
      k = kindOf(opcode);
      if (k < 0) begin
        mHalt = 1'b1;
      end else begin
        mKind = k;
        plan.delete();
        plan.push_back(2);
        if (k == 1 || k == 2) plan.push_back(3);
        if (k == 0 || k == 1 || k == 5) plan.push_back(4);
        mPh = plan.pop_front();
      end
    end else if (mPh == 3 && !mem_rdy) begin
      mPh = 3;
    end else if (plan.size() > 0) begin
      mPh = plan.pop_front();
    end else if (run) begin
      mPh = 0;
    end else begin
      mIdle = 1'b1;
    end
  endtask

  function automatic logic [20:0] expected();
    logic [4:0] ep;
    logic pcw, irw, iod, mr, mw, m2r, rw, rd, asa;
    logic [1:0] asb, aop, pcs;
    ep = 5'b0; pcw = 0; irw = 0; iod = 0; mr = 0; mw = 0; m2r = 0; rw = 0; rd = 0; asa = 0;
    asb = 2'b00; aop = 2'b00; pcs = 2'b00;
    if (!mIdle && !mHalt) begin
      ep = 5'(1 << mPh);
      case (mPh)
        0: begin mr = 1; asb = 2'b01; irw = mem_rdy; pcw = mem_rdy; end
        1: asb = 2'b11;
        2: begin
          case (mKind)
            0: begin asa = 1; aop = 2'b10; end
            1, 2, 5: begin asa = 1; asb = 2'b10; end
            3: begin asa = 1; aop = 2'b01; pcs = 2'b01; pcw = zero; end
            default: begin pcs = 2'b10; pcw = 1; end
          endcase
        end
        3: begin iod = 1; mr = (mKind == 1); mw = (mKind == 2); end
        default: begin rw = 1; rd = (mKind == 0); m2r = (mKind == 1); end
      endcase
    end
    return {ep, pcw, irw, iod, mr, mw, m2r, rw, rd, asa, asb, aop, pcs, mHalt};
  endfunction

  task automatic checkOutput();
    logic [20:0] got, exp;
    if (!checkEn) return;
    got = {p, pc_write, ir_write, i_or_d, mem_read, mem_write, mem_to_reg, reg_write,
           reg_dst, alu_src_a, alu_src_b, alu_op, pc_src, halted};
    exp = expected();
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL outputs cyc=%0d got=%h expected=%h", cyc, got, exp);
    end
  endtask

  task automatic checkLit(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s cyc=%0d got=%h expected=%h", name, cyc, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic n, input logic r, input logic [5:0] op,
                               input logic z, input logic rdy);
    @(posedge clk);
    modelStep();
    cyc++;
    #1;
    nclr    = n;
    run     = r;
    opcode  = op;
    zero    = z;
    mem_rdy = rdy;
    @(negedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    legalOps[0] = OP_R;  legalOps[1] = OP_LW;  legalOps[2] = OP_SW;
    legalOps[3] = OP_BEQ; legalOps[4] = OP_J;  legalOps[5] = OP_ADDI;

    applyStimulus(1'b0, 1'b0, OP_LW, 1'b0, 1'b1);
    checkEn = 1'b1;

    // reset then lw with memory always ready
    applyStimulus(1'b1, 1'b1, OP_LW, 1'b0, 1'b1);
    checkLit("reset_p", 8'(p), 8'h00);
    checkLit("reset_halted", 8'(halted), 8'h00);
    applyStimulus(1'b1, 1'b1, OP_LW, 1'b0, 1'b1);
    checkLit("lw_if_p", 8'(p), 8'h01);
    checkLit("lw_if_irw", 8'(ir_write), 8'h01);
    applyStimulus(1'b1, 1'b1, OP_LW, 1'b0, 1'b1);
    checkLit("lw_id_p", 8'(p), 8'h02);
    applyStimulus(1'b1, 1'b1, OP_LW, 1'b0, 1'b1);
    checkLit("lw_ex_p", 8'(p), 8'h04);
    applyStimulus(1'b1, 1'b1, OP_LW, 1'b0, 1'b1);
    checkLit("lw_mem_p", 8'(p), 8'h08);
    checkLit("lw_mem_rw", 8'(reg_write), 8'h00);
    applyStimulus(1'b1, 1'b1, OP_BEQ, 1'b1, 1'b1);
    checkLit("lw_wb_p", 8'(p), 8'h10);
    checkLit("lw_wb_rw_m2r", 8'({reg_write, mem_to_reg}), 8'h03);

    // beq taken then not taken
    applyStimulus(1'b1, 1'b1, OP_BEQ, 1'b1, 1'b1);
    checkLit("beq1_if_p", 8'(p), 8'h01);
    applyStimulus(1'b1, 1'b1, OP_BEQ, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1, OP_BEQ, 1'b1, 1'b1);
    checkLit("beq1_ex_pcw_src", 8'({pc_write, pc_src}), 8'h05);
    applyStimulus(1'b1, 1'b1, OP_BEQ, 1'b0, 1'b1);
    checkLit("beq2_if_p", 8'(p), 8'h01);
    applyStimulus(1'b1, 1'b1, OP_BEQ, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, OP_BEQ, 1'b0, 1'b1);
    checkLit("beq2_ex_pcw", 8'({p, pc_write}), 8'h08);
    applyStimulus(1'b1, 1'b1, OP_SW, 1'b0, 1'b1);
    checkLit("beq2_next_if", 8'(p), 8'h01);

    // sw with three stalled MEM cycles
    applyStimulus(1'b1, 1'b1, OP_SW, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, OP_SW, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, OP_SW, 1'b0, 1'b0);
      checkLit("sw_stall_mem", 8'({p, mem_write, reg_write}), 8'h22);
    end
    applyStimulus(1'b1, 1'b1, OP_BAD, 1'b0, 1'b1);
    checkLit("sw_last_mem", 8'({p, mem_write, reg_write}), 8'h22);
    applyStimulus(1'b1, 1'b1, OP_BAD, 1'b0, 1'b1);
    checkLit("sw_then_if", 8'(p), 8'h01);

    // illegal opcode halts until reset
    applyStimulus(1'b1, 1'b1, OP_BAD, 1'b0, 1'b1);
    checkLit("bad_id_p", 8'(p), 8'h02);
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b1, 1'($urandom_range(0, 1)), OP_BAD, 1'b0, 1'($urandom_range(0, 1)));
      checkLit("halt_state", 8'({halted, p, pc_write}), 8'h40);
    end
    applyStimulus(1'b0, 1'b0, OP_R, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, OP_R, 1'b0, 1'b0);
    checkLit("halt_cleared", 8'({halted, p}), 8'h00);

    // reset during an IF stall
    applyStimulus(1'b1, 1'b1, OP_R, 1'b0, 1'b0);
    checkLit("stall_if_p", 8'({p, ir_write}), 8'h02);
    applyStimulus(1'b0, 1'b1, OP_R, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, OP_R, 1'b0, 1'b1);
    checkLit("stall_reset_idle", 8'({p, pc_write}), 8'h00);

    // run dropped during R-type EX
    applyStimulus(1'b1, 1'b1, OP_R, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, OP_R, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, OP_R, 1'b0, 1'b1);
    checkLit("rt_ex_p", 8'(p), 8'h04);
    applyStimulus(1'b1, 1'b0, OP_R, 1'b0, 1'b1);
    checkLit("rt_wb", 8'({p, reg_write, reg_dst}), 8'h43);
    applyStimulus(1'b1, 1'b0, OP_R, 1'b0, 1'b1);
    checkLit("rt_then_idle", 8'(p), 8'h00);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic n, r, z, rdy;
      logic [5:0] op;
      n   = mHalt ? ($urandom_range(0, 99) >= 15) : ($urandom_range(0, 99) >= 3);
      r   = ($urandom_range(0, 99) < 85);
      z   = 1'($urandom_range(0, 1));
      rdy = ($urandom_range(0, 99) < 70);
      op  = ($urandom_range(0, 99) < 90) ? legalOps[$urandom_range(0, 5)] : 6'($urandom);
      applyStimulus(n, r, op, z, rdy);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
